// File: rtl/jailbreak_hiscore_ctrl.sv
// jailbreak_hiscore_ctrl: range-table dump/restore sequencer in front of the k005849 high-score port.
// Define HISCORE_CHECKSUM_EN to append (dump) / verify (restore) an 8-bit modular sum after the last range.
module jailbreak_hiscore_ctrl #(
  parameter int ENTRIES = 4,
  parameter int RD_LAT  = 2,
  parameter int SETTLE  = 16
) (
  input  logic        clk_49m,
  input  logic        reset,
  input  logic        cfg_wr,
  input  logic [3:0]  cfg_idx,
  input  logic [11:0] cfg_start,
  input  logic [7:0]  cfg_len,
  input  logic        cfg_valid,
  input  logic        dump_start,
  input  logic        restore_start,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  up_data,
  output logic        up_valid,
  input  logic        up_ready,
  input  logic [7:0]  dn_data,
  input  logic        dn_valid,
  output logic        dn_ready,
  output logic        pause_req,
  output logic [11:0] hs_address,
  output logic [7:0]  hs_data_in,
  output logic        hs_write_enable,
  output logic        hs_access_write,
  input  logic [7:0]  hs_data_out
);
  localparam int IW = ENTRIES > 1 ? $clog2(ENTRIES) : 1;
  typedef enum logic [3:0] {
    IDLE, PAUSE, SCAN, RD_ADDR, RD_WAIT, RD_PUSH, WR_PULL, WR_STROBE, DONE, CK_PUSH, CK_PULL
  } state_t;
  state_t state, state_n, fin;
  logic mode, acc, err_q, at_end, slot_ok, step;
  logic [4:0] idx;
  logic [IW-1:0] ix;
  logic [7:0] cnt, rem, up_q, din_q;
  logic [11:0] addr;
  logic [11:0] t_start [ENTRIES];
  logic [7:0] t_len [ENTRIES];
  logic [ENTRIES-1:0] t_valid;
`ifdef HISCORE_CHECKSUM_EN
  logic [7:0] sum;
  assign fin = mode ? CK_PULL : CK_PUSH;
`else
  assign fin = DONE;
`endif
  assign ix      = idx[IW-1:0];
  assign at_end  = idx == 5'(ENTRIES);
  assign slot_ok = t_valid[ix];
  assign step    = (state == RD_PUSH && up_ready) || state == WR_STROBE;
  always_ff @(posedge clk_49m) begin
    if (reset) begin
      state   <= IDLE;
      mode    <= 1'b0;
      acc     <= 1'b0;
      err_q   <= 1'b0;
      idx     <= '0;
      cnt     <= '0;
      rem     <= '0;
      addr    <= '0;
      up_q    <= '0;
      din_q   <= '0;
      t_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        t_start[i] <= '0;
        t_len[i]   <= '0;
      end
`ifdef HISCORE_CHECKSUM_EN
      sum <= '0;
`endif
    end else begin
      state <= state_n;
      cnt   <= state_n == state ? cnt + 8'd1 : 8'd0;
      acc   <= state_n == WR_PULL || (acc && state_n != DONE && state_n != IDLE);
      if (state == IDLE && cfg_wr && {1'b0, cfg_idx} < 5'(ENTRIES)) begin
        t_start[cfg_idx[IW-1:0]] <= cfg_start;
        t_len[cfg_idx[IW-1:0]]   <= cfg_len;
        t_valid[cfg_idx[IW-1:0]] <= cfg_valid;
      end
      if (state == IDLE && (dump_start || restore_start)) begin
        mode  <= !dump_start;
        idx   <= '0;
        err_q <= 1'b0;
`ifdef HISCORE_CHECKSUM_EN
        sum <= '0;
`endif
      end
      if (state == SCAN && !at_end) begin
        if (slot_ok) begin
          addr <= t_start[ix];
          rem  <= t_len[ix];
        end else begin
          idx <= idx + 5'd1;
        end
      end
      if (state == RD_WAIT && cnt == 8'(RD_LAT - 1)) up_q <= hs_data_out;
      if (state == WR_PULL && dn_valid) din_q <= dn_data;
      if (step) begin
        if (rem == 8'd0) begin
          idx <= idx + 5'd1;
        end else begin
          addr <= addr + 12'd1;
          rem  <= rem - 8'd1;
        end
      end
`ifdef HISCORE_CHECKSUM_EN
      if (state == RD_PUSH && up_ready) sum <= sum + up_q;
      if (state == WR_PULL && dn_valid) sum <= sum + dn_data;
      if (state == SCAN && at_end) up_q <= sum;
      if (state == CK_PULL && dn_valid) err_q <= dn_data != sum;
`endif
    end
  end
  // PAUSE runs SETTLE+1 cycles so the first SCAN starts after a full settle window
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = (dump_start || restore_start) ? PAUSE : IDLE;
      PAUSE:     state_n = cnt == 8'(SETTLE) ? SCAN : PAUSE;
      SCAN:      state_n = at_end ? fin : !slot_ok ? SCAN : mode ? WR_PULL : RD_ADDR;
      RD_ADDR:   state_n = RD_WAIT;
      RD_WAIT:   state_n = cnt == 8'(RD_LAT - 1) ? RD_PUSH : RD_WAIT;
      RD_PUSH:   state_n = !up_ready ? RD_PUSH : rem == 8'd0 ? SCAN : RD_ADDR;
      WR_PULL:   state_n = dn_valid ? WR_STROBE : WR_PULL;
      WR_STROBE: state_n = rem == 8'd0 ? SCAN : WR_PULL;
      CK_PUSH:   state_n = up_ready ? DONE : CK_PUSH;
      CK_PULL:   state_n = dn_valid ? DONE : CK_PULL;
      DONE:      state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end
  always_comb begin
    busy            = state != IDLE && state != DONE;
    pause_req       = state != IDLE && state != DONE;
    done            = state == DONE;
    err             = err_q;
    up_valid        = state == RD_PUSH || state == CK_PUSH;
    up_data         = up_q;
    dn_ready        = state == WR_PULL || state == CK_PULL;
    hs_address      = addr;
    hs_data_in      = din_q;
    hs_write_enable = state == WR_STROBE;
    hs_access_write = acc;
  end
endmodule

// File: tb/tb_jailbreak_hiscore_ctrl.sv
// tb_jailbreak_hiscore_ctrl: directed-vector bench for jailbreak_hiscore_ctrl with a 2-cycle-latency RAM model.
module tb_jailbreak_hiscore_ctrl;
`ifdef HISCORE_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif
  logic clk_49m = 1'b0, reset = 1'b1;
  logic cfg_wr = 1'b0, cfg_valid = 1'b0, dump_start = 1'b0, restore_start = 1'b0;
  logic [3:0] cfg_idx = '0;
  logic [11:0] cfg_start = '0;
  logic [7:0] cfg_len = '0, dn_data = '0;
  logic up_ready = 1'b0, dn_valid = 1'b0;
  logic busy, done, err, up_valid, dn_ready, pause_req, hs_write_enable, hs_access_write;
  logic [7:0] up_data, hs_data_in, hs_data_out;
  logic [11:0] hs_address;
  logic [7:0] ram [4096];
  logic [7:0] rd1, rd2;
  logic [11:0] up_a[$], wr_a[$];
  logic [7:0] up_d[$], wr_d[$], dnq[$];
  int done_cnt = 0, pause_bad = 0, wr_bad = 0;
  int vecs = 0, errs = 0;

  jailbreak_hiscore_ctrl dut (
    .clk_49m(clk_49m), .reset(reset), .cfg_wr(cfg_wr), .cfg_idx(cfg_idx), .cfg_start(cfg_start),
    .cfg_len(cfg_len), .cfg_valid(cfg_valid), .dump_start(dump_start), .restore_start(restore_start),
    .busy(busy), .done(done), .err(err), .up_data(up_data), .up_valid(up_valid), .up_ready(up_ready),
    .dn_data(dn_data), .dn_valid(dn_valid), .dn_ready(dn_ready), .pause_req(pause_req),
    .hs_address(hs_address), .hs_data_in(hs_data_in), .hs_write_enable(hs_write_enable),
    .hs_access_write(hs_access_write), .hs_data_out(hs_data_out)
  );

  always #10 clk_49m = ~clk_49m;
  always @(posedge clk_49m) begin
    rd1 <= ram[hs_address];
    rd2 <= rd1;
  end
  assign hs_data_out = rd2;
  always @(posedge clk_49m) begin
    if (done) done_cnt++;
    if (up_valid && up_ready) begin
      up_a.push_back(hs_address);
      up_d.push_back(up_data);
      if (!pause_req) pause_bad++;
    end
    if (hs_write_enable) begin
      wr_a.push_back(hs_address);
      wr_d.push_back(hs_data_in);
      if (!hs_access_write || !pause_req) wr_bad++;
    end
  end

  task automatic tick();
    @(posedge clk_49m);
    #1;
  endtask

  task automatic cfg(input int i, input logic [11:0] s, input logic [7:0] l, input logic v);
    cfg_idx = 4'(i); cfg_start = s; cfg_len = l; cfg_valid = v; cfg_wr = 1'b1;
    tick();
    cfg_wr = 1'b0;
  endtask

  task automatic clear_table();
    for (int i = 0; i < 4; i++) cfg(i, 12'h000, 8'h00, 1'b0);
  endtask

  task automatic start_op(input logic d, input logic r);
    dump_start = d; restore_start = r;
    tick();
    dump_start = 1'b0; restore_start = 1'b0;
  endtask

  task automatic clear_logs();
    up_a.delete(); up_d.delete(); wr_a.delete(); wr_d.delete();
  endtask

  // feeds dnq into the restore stream until done, counting busy cycles
  task automatic wait_done(input int limit, output int bc);
    logic ok, hs;
    bc = 0; ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (busy) bc++;
      dn_valid = dnq.size() > 0;
      dn_data = dn_valid ? dnq[0] : 8'h00;
      hs = dn_valid && dn_ready;
      tick();
      if (hs) void'(dnq.pop_front());
    end
    dn_valid = 1'b0;
    vecs++;
    if (!ok) begin
      errs++;
      $display("FAIL done_timeout: no done within %0d cycles", limit);
    end else begin
      tick();
      vecs++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errs++;
        $display("FAIL done_pulse: done=%b busy=%b one cycle after done, want 0 0", done, busy);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    vecs++;
    if ({busy, done, err, up_valid, dn_ready, pause_req, hs_write_enable, hs_access_write} !== 8'h00) begin
      errs++;
      $display("FAIL reset_ctrl: got %b want 00000000",
               {busy, done, err, up_valid, dn_ready, pause_req, hs_write_enable, hs_access_write});
    end
    vecs++;
    if (up_data !== 8'h00 || hs_data_in !== 8'h00 || hs_address !== 12'h000) begin
      errs++;
      $display("FAIL reset_data: up_data=%h hs_data_in=%h hs_address=%h want 0", up_data, hs_data_in, hs_address);
    end
  endtask

  task automatic test_all_invalid();
    int bc, d0;
    clear_table();
    cfg(4, 12'h700, 8'h00, 1'b1);
    cfg(12, 12'h710, 8'h00, 1'b1);
    up_ready = 1'b1; clear_logs(); d0 = done_cnt;
    start_op(1'b1, 1'b0);
    wait_done(200, bc);
    vecs++;
    if (bc != 16 + 4 + 2 + CK) begin
      errs++;
      $display("FAIL empty_busy: got %0d busy cycles want %0d", bc, 16 + 4 + 2 + CK);
    end
    vecs++;
    if (up_d.size() != CK) begin
      errs++;
      $display("FAIL empty_traffic: got %0d up bytes want %0d", up_d.size(), CK);
    end
    vecs++;
    if (done_cnt - d0 != 1) begin
      errs++;
      $display("FAIL empty_done: got %0d done pulses want 1", done_cnt - d0);
    end
`ifdef HISCORE_CHECKSUM_EN
    vecs++;
    if (up_d.size() != 1 || up_d[0] !== 8'h00) begin
      errs++;
      $display("FAIL empty_sum: got %0d bytes, want single 00", up_d.size());
    end
`endif
  endtask

  task automatic test_dump();
    int bc, d0;
    logic [7:0] e [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    clear_table();
    cfg(0, 12'h100, 8'd3, 1'b1);
    up_ready = 1'b1; clear_logs(); d0 = done_cnt; pause_bad = 0;
    start_op(1'b1, 1'b0);
    wait_done(300, bc);
    vecs++;
    if (up_d.size() != 4 + CK) begin
      errs++;
      $display("FAIL dump_count: got %0d bytes want %0d", up_d.size(), 4 + CK);
    end
    for (int i = 0; i < 4; i++) begin
      vecs++;
      if (up_d.size() <= i || up_d[i] !== e[i] || up_a[i] !== 12'(12'h100 + i)) begin
        errs++;
        $display("FAIL dump_byte%0d: got %h@%h want %h@%h", i, up_d[i], up_a[i], e[i], 12'(12'h100 + i));
      end
    end
`ifdef HISCORE_CHECKSUM_EN
    vecs++;
    if (up_d.size() != 5 || up_d[4] !== 8'hAA) begin
      errs++;
      $display("FAIL dump_sum: got %h want aa", up_d[4]);
    end
`endif
    vecs++;
    if (done_cnt - d0 != 1 || pause_bad != 0 || err !== 1'b0) begin
      errs++;
      $display("FAIL dump_status: done=%0d pause_gaps=%0d err=%b want 1 0 0", done_cnt - d0, pause_bad, err);
    end
  endtask

  task automatic test_restore();
    int bc, wb;
    clear_table();
    cfg(1, 12'h200, 8'd1, 1'b1);
    clear_logs(); wb = wr_bad;
    dnq = '{8'h5A, 8'hA5};
`ifdef HISCORE_CHECKSUM_EN
    dnq.push_back(8'hFF);
`endif
    start_op(1'b0, 1'b1);
    wait_done(300, bc);
    vecs++;
    if (wr_a.size() != 2) begin
      errs++;
      $display("FAIL restore_count: got %0d writes want 2", wr_a.size());
    end
    vecs++;
    if (wr_a.size() < 2 || wr_a[0] !== 12'h200 || wr_d[0] !== 8'h5A || wr_a[1] !== 12'h201 || wr_d[1] !== 8'hA5) begin
      errs++;
      $display("FAIL restore_data: got %h=%h %h=%h want 200=5a 201=a5", wr_a[0], wr_d[0], wr_a[1], wr_d[1]);
    end
    vecs++;
    if (wr_bad != wb || hs_access_write !== 1'b0 || err !== 1'b0 || dnq.size() != 0) begin
      errs++;
      $display("FAIL restore_status: bad_strobes=%0d access=%b err=%b left=%0d want 0 0 0 0",
               wr_bad - wb, hs_access_write, err, dnq.size());
    end
`ifdef HISCORE_CHECKSUM_EN
    clear_logs();
    dnq = '{8'h5A, 8'hA5, 8'h00};
    start_op(1'b0, 1'b1);
    wait_done(300, bc);
    vecs++;
    if (err !== 1'b1 || wr_a.size() != 2) begin
      errs++;
      $display("FAIL restore_badsum: err=%b writes=%0d want 1 2", err, wr_a.size());
    end
`endif
  endtask

  task automatic test_backpressure();
    int bc, n;
    logic [7:0] e [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    clear_table();
    cfg(0, 12'h300, 8'd3, 1'b1);
    up_ready = 1'b0; clear_logs();
    start_op(1'b1, 1'b0);
    n = 0;
    while (!up_valid && n < 100) begin
      tick();
      n++;
    end
    vecs++;
    if (up_valid !== 1'b1 || up_data !== 8'hA1 || hs_address !== 12'h300) begin
      errs++;
      $display("FAIL bp_first: valid=%b data=%h addr=%h want 1 a1 300", up_valid, up_data, hs_address);
    end
    repeat (10) begin
      tick();
      vecs++;
      if (up_valid !== 1'b1 || up_data !== 8'hA1 || hs_address !== 12'h300) begin
        errs++;
        $display("FAIL bp_hold: valid=%b data=%h addr=%h want 1 a1 300", up_valid, up_data, hs_address);
      end
    end
    up_ready = 1'b1;
    wait_done(300, bc);
    vecs++;
    if (up_d.size() != 4 + CK) begin
      errs++;
      $display("FAIL bp_count: got %0d bytes want %0d", up_d.size(), 4 + CK);
    end
    for (int i = 0; i < 4; i++) begin
      vecs++;
      if (up_d.size() <= i || up_d[i] !== e[i]) begin
        errs++;
        $display("FAIL bp_byte%0d: got %h want %h", i, up_d[i], e[i]);
      end
    end
`ifdef HISCORE_CHECKSUM_EN
    vecs++;
    if (up_d.size() != 5 || up_d[4] !== 8'h8A) begin
      errs++;
      $display("FAIL bp_sum: got %h want 8a", up_d[4]);
    end
`endif
  endtask

  task automatic test_wrap();
    int bc;
    logic [11:0] ea [4] = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
    logic [7:0] e [4] = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    clear_table();
    cfg(3, 12'hFFE, 8'd3, 1'b1);
    up_ready = 1'b1; clear_logs();
    start_op(1'b1, 1'b0);
    wait_done(300, bc);
    for (int i = 0; i < 4; i++) begin
      vecs++;
      if (up_d.size() <= i || up_a[i] !== ea[i] || up_d[i] !== e[i]) begin
        errs++;
        $display("FAIL wrap%0d: got %h@%h want %h@%h", i, up_d[i], up_a[i], e[i], ea[i]);
      end
    end
`ifdef HISCORE_CHECKSUM_EN
    vecs++;
    if (up_d.size() != 5 || up_d[4] !== 8'h0A) begin
      errs++;
      $display("FAIL wrap_sum: got %h want 0a", up_d[4]);
    end
`endif
    vecs++;
    if (err !== 1'b0) begin
      errs++;
      $display("FAIL wrap_err: got %b want 0", err);
    end
  endtask

  task automatic test_reset_mid();
    int bc, n;
    logic hs;
    clear_table();
    cfg(0, 12'h400, 8'd3, 1'b1);
    clear_logs();
    dnq = '{8'hD1, 8'hD2, 8'hD3, 8'hD4};
    start_op(1'b0, 1'b1);
    n = 0;
    while (wr_a.size() < 2 && n < 200) begin
      dn_valid = dnq.size() > 0;
      dn_data = dn_valid ? dnq[0] : 8'h00;
      hs = dn_valid && dn_ready;
      tick();
      if (hs) void'(dnq.pop_front());
      n++;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    dn_valid = 1'b1; dn_data = 8'hEE;
    vecs++;
    if ({busy, done, err, up_valid, dn_ready, pause_req, hs_write_enable, hs_access_write} !== 8'h00 ||
        hs_address !== 12'h000 || hs_data_in !== 8'h00 || up_data !== 8'h00) begin
      errs++;
      $display("FAIL midreset_outputs: ctrl=%b addr=%h din=%h want all 0",
               {busy, done, err, up_valid, dn_ready, pause_req, hs_write_enable, hs_access_write}, hs_address, hs_data_in);
    end
    repeat (20) tick();
    dn_valid = 1'b0;
    vecs++;
    if (wr_a.size() != 2 || busy !== 1'b0) begin
      errs++;
      $display("FAIL midreset_quiet: got %0d writes busy=%b want 2 0", wr_a.size(), busy);
    end
    cfg(0, 12'h400, 8'd3, 1'b1);
    clear_logs();
    dnq = '{8'hD1, 8'hD2, 8'hD3, 8'hD4};
`ifdef HISCORE_CHECKSUM_EN
    dnq.push_back(8'h4A);
`endif
    start_op(1'b0, 1'b1);
    wait_done(300, bc);
    vecs++;
    if (wr_a.size() != 4 || err !== 1'b0) begin
      errs++;
      $display("FAIL fresh_restore: got %0d writes err=%b want 4 0", wr_a.size(), err);
    end
    for (int i = 0; i < 4; i++) begin
      vecs++;
      if (wr_a.size() <= i || wr_a[i] !== 12'(12'h400 + i) || wr_d[i] !== 8'(8'hD1 + i)) begin
        errs++;
        $display("FAIL fresh_write%0d: got %h=%h want %h=%h", i, wr_a[i], wr_d[i], 12'(12'h400 + i), 8'(8'hD1 + i));
      end
    end
  endtask

  task automatic test_back_to_back();
    int bc;
    clear_table();
    cfg(0, 12'h100, 8'd3, 1'b1);
    up_ready = 1'b1; clear_logs();
    start_op(1'b1, 1'b1);
    cfg(0, 12'h555, 8'd7, 1'b0);
    wait_done(300, bc);
    vecs++;
    if (up_d.size() != 4 + CK || up_d[0] !== 8'h11 || up_d[3] !== 8'h44 || wr_a.size() != 0) begin
      errs++;
      $display("FAIL simul_dump: bytes=%0d first=%h last=%h writes=%0d want %0d 11 44 0",
               up_d.size(), up_d[0], up_d[3], wr_a.size(), 4 + CK);
    end
    clear_logs();
    start_op(1'b1, 1'b0);
    start_op(1'b0, 1'b1);
    wait_done(300, bc);
    vecs++;
    if (up_d.size() != 4 + CK || up_a[0] !== 12'h100 || up_d[0] !== 8'h11 || up_d[3] !== 8'h44 || wr_a.size() != 0) begin
      errs++;
      $display("FAIL table_kept: bytes=%0d addr0=%h first=%h last=%h writes=%0d want %0d 100 11 44 0",
               up_d.size(), up_a[0], up_d[0], up_d[3], wr_a.size(), 4 + CK);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    ram[12'h100] = 8'h11; ram[12'h101] = 8'h22; ram[12'h102] = 8'h33; ram[12'h103] = 8'h44;
    ram[12'h300] = 8'hA1; ram[12'h301] = 8'hA2; ram[12'h302] = 8'hA3; ram[12'h303] = 8'hA4;
    ram[12'hFFE] = 8'hC1; ram[12'hFFF] = 8'hC2; ram[12'h000] = 8'hC3; ram[12'h001] = 8'hC4;
    test_reset();
    test_all_invalid();
    test_dump();
    test_restore();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
